// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch/halt opcodes, condition codes and the
// program-counter FSM state type. Imported by pc_unit and branch_cond.
package cpu_pkg;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] CC_NE = 3'b000;  // ~Z
  localparam logic [2:0] CC_EQ = 3'b001;  // Z
  localparam logic [2:0] CC_GT = 3'b010;  // ~Z & ~N
  localparam logic [2:0] CC_LT = 3'b011;  // N
  localparam logic [2:0] CC_GE = 3'b100;  // Z | ~N
  localparam logic [2:0] CC_LE = 3'b101;  // Z | N
  localparam logic [2:0] CC_OV = 3'b110;  // V
  localparam logic [2:0] CC_AL = 3'b111;  // always

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_WAIT_FLAGS = 2'd1,
    ST_HALT       = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-side bus of the program-counter unit.
//   master : fetch/decode side, drives instr, instr_valid, stall, flags,
//            flags_valid, rs_data; observes pc, pc_plus2, branch_taken, halted
//   slave  : pc_unit itself
interface pc_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               stall;
  logic [2:0]         flags;        // {V,N,Z}
  logic               flags_valid;
  logic [ADDR_W-1:0]  rs_data;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_plus2;
  logic               branch_taken;
  logic               halted;

  modport master (
    output instr, instr_valid, stall, flags, flags_valid, rs_data,
    input  pc, pc_plus2, branch_taken, halted
  );

  modport slave (
    input  instr, instr_valid, stall, flags, flags_valid, rs_data,
    output pc, pc_plus2, branch_taken, halted
  );
endinterface

// File: rtl/pc_unit_branch_cond.sv
// branch_cond: combinational condition-code evaluator.
//   cc    in  3  condition code
//   flags in  3  {V,N,Z}
//   pass  out 1  condition holds
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [2:0] flags,
  output logic       pass
);
  logic flag_v, flag_n, flag_z;
  assign {flag_v, flag_n, flag_z} = flags;

  always_comb begin
    pass = 1'b0;
    unique case (cc)
      CC_NE: pass = ~flag_z;
      CC_EQ: pass = flag_z;
      CC_GT: pass = ~flag_z & ~flag_n;
      CC_LT: pass = flag_n;
      CC_GE: pass = flag_z | ~flag_n;
      CC_LE: pass = flag_z | flag_n;
      CC_OV: pass = flag_v;
      CC_AL: pass = 1'b1;
    endcase
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with branch resolution.
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-low reset
//   bus            slave modport of pc_unit_if (instr/flags/rs_data in,
//                  pc/pc_plus2/branch_taken/halted out)
//   perf_taken_cnt out  saturating taken-branch count, present only when
//                  the macro PC_PERF_EN is defined
//
// state      | meaning
// RUN        | normal fetch; pc advances on each accepted instruction
// WAIT_FLAGS | branch fetched before its flags were valid; pc held
// HALT       | HLT accepted; pc frozen until reset
module pc_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              INSTR_W  = 16,
  parameter int              IMM_W    = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic      clk,
  input  logic      rst,
  pc_unit_if.slave  bus
`ifdef PC_PERF_EN
  ,
  output logic [15:0] perf_taken_cnt
`endif
);

  pc_state_t          state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               branch_taken_q, taken_d;
  logic               halted_q;

  logic [3:0]         op;
  logic [2:0]         cc;
  logic signed [IMM_W-1:0]  imm;
  logic [ADDR_W-1:0]  imm_ext;
  logic [ADDR_W-1:0]  pc_plus2;
  logic [ADDR_W-1:0]  b_target;
  logic [ADDR_W-1:0]  br_target;
  logic               is_branch;
  logic               cond_pass;
  logic               accept;
  logic               unused_rs0;

  assign op        = bus.instr[INSTR_W-1 -: 4];
  assign cc        = bus.instr[INSTR_W-5 -: 3];
  assign imm       = bus.instr[IMM_W-1:0];
  assign imm_ext   = ADDR_W'(imm);  // signed size cast sign-extends
  assign pc_plus2  = pc_q + ADDR_W'(2);
  assign b_target  = pc_plus2 + {imm_ext[ADDR_W-2:0], 1'b0};
  assign br_target = {bus.rs_data[ADDR_W-1:1], 1'b0};
  assign unused_rs0 = bus.rs_data[0];
  assign is_branch = (op == OP_B) || (op == OP_BR);
  assign accept    = bus.instr_valid & ~bus.stall;

  branch_cond u_branch_cond (
    .cc    (cc),
    .flags (bus.flags),
    .pass  (cond_pass)
  );

  // WAIT_FLAGS re-enters the RUN decode once flags are valid, so both
  // states share one resolution path.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
    unique case (state_q)
      ST_RUN, ST_WAIT_FLAGS: begin
        if (accept && (state_q == ST_RUN || bus.flags_valid)) begin
          if (op == OP_HLT) begin
            state_d = ST_HALT;
          end else if (is_branch && !bus.flags_valid) begin
            state_d = ST_WAIT_FLAGS;
          end else begin
            state_d = ST_RUN;
            if (is_branch && cond_pass) begin
              taken_d = 1'b1;
              pc_d    = (op == OP_B) ? b_target : br_target;
            end else begin
              pc_d = pc_plus2;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_RUN;
      pc_q           <= RESET_PC;
      branch_taken_q <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      branch_taken_q <= taken_d;
      halted_q       <= (state_d == ST_HALT);
    end
  end

`ifdef PC_PERF_EN
  logic [15:0] perf_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cnt_q <= '0;
    end else if (taken_d && perf_cnt_q != 16'hFFFF) begin
      perf_cnt_q <= perf_cnt_q + 16'd1;
    end
  end

  assign perf_taken_cnt = perf_cnt_q;
`endif

  assign bus.pc           = pc_q;
  assign bus.pc_plus2     = pc_plus2;
  assign bus.branch_taken = branch_taken_q;
  assign bus.halted       = halted_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  localparam int ADDR_W = 16;
  localparam int INSTR_W = 16;
  localparam int IMM_W = 9;
  localparam logic [15:0] RST_PC = 16'h0000;

  localparam logic [15:0] I_ADD  = 16'h1000;
  localparam logic [15:0] I_BEQ  = 16'hC3FE;  // B cc=001 imm=-2
  localparam logic [15:0] I_BRAL = 16'hDE00;  // BR cc=111
  localparam logic [15:0] I_HLT  = 16'hF000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  // reference model state
  int   m_pc;
  bit   m_halt;
  bit   m_wait;
  bit   m_taken;
  int   m_cnt;

  pc_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

`ifdef PC_PERF_EN
  logic [15:0] perf;
`endif

  pc_unit #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .IMM_W(IMM_W), .RESET_PC(RST_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PC_PERF_EN
    ,
    .perf_taken_cnt (perf)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit cond_ok(input logic [2:0] cc, input logic [2:0] fl);
    bit v, n, z;
    v = fl[2]; n = fl[1]; z = fl[0];
    case (cc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = int'(RST_PC); m_halt = 0; m_wait = 0; m_taken = 0; m_cnt = 0;
  endtask

  task automatic model_update(input logic [15:0] ins, input bit iv, input bit st,
                              input logic [2:0] fl, input bit fv, input logic [15:0] rs);
    int op, imm;
    m_taken = 0;
    if (m_halt || !iv || st) return;
    if (m_wait && !fv) return;
    op  = int'(ins[15:12]);
    imm = int'(ins[8:0]);
    if (imm >= 256) imm -= 512;
    if (op == 15) begin
      m_halt = 1; m_wait = 0;
    end else if (op == 12 || op == 13) begin
      if (!fv) begin
        m_wait = 1;
      end else begin
        m_wait = 0;
        if (cond_ok(ins[11:9], fl)) begin
          m_taken = 1;
          if (m_cnt < 65535) m_cnt++;
          m_pc = (op == 12) ? ((m_pc + 2 + 2 * imm) & 'hFFFF) : (int'(rs) & 'hFFFE);
        end else begin
          m_pc = (m_pc + 2) & 'hFFFF;
        end
      end
    end else begin
      m_wait = 0;
      m_pc = (m_pc + 2) & 'hFFFF;
    end
  endtask

  // drive one cycle of inputs, advance the model, sample 1 time unit after the edge
  task automatic step(input logic [15:0] ins, input bit iv, input bit st,
                      input logic [2:0] fl, input bit fv, input logic [15:0] rs);
    bus.instr = ins; bus.instr_valid = iv; bus.stall = st;
    bus.flags = fl; bus.flags_valid = fv; bus.rs_data = rs;
    model_update(ins, iv, st, fl, fv, rs);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.instr = I_ADD; bus.instr_valid = 1; bus.stall = 0;
    bus.flags = 3'b001; bus.flags_valid = 1; bus.rs_data = '0;
    rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    if (bus.pc !== RST_PC) begin n_err++; $display("FAIL reset_pc got %h want %h", bus.pc, RST_PC); end
    n_cmp++;
    if (bus.halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", bus.halted); end
    n_cmp++;
    if (bus.branch_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken got %b want 0", bus.branch_taken); end
    n_cmp++;
`ifdef PC_PERF_EN
    if (perf !== 16'h0) begin n_err++; $display("FAIL reset_perf got %h want 0000", perf); end
    n_cmp++;
`endif
    bus.instr_valid = 0;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_sequential();
    logic [15:0] want;
    for (int i = 1; i <= 4; i++) begin
      step(I_ADD, 1, 0, 3'b000, 1, 16'h0);
      want = 16'(2 * i);
      if (bus.pc !== want) begin n_err++; $display("FAIL seq_pc[%0d] got %h want %h", i, bus.pc, want); end
      n_cmp++;
      if (bus.branch_taken !== 1'b0) begin n_err++; $display("FAIL seq_taken[%0d] got %b want 0", i, bus.branch_taken); end
      n_cmp++;
    end
  endtask

  task automatic test_branch_b();
    repeat (4) step(I_ADD, 1, 0, 3'b000, 1, 16'h0);
    if (bus.pc !== 16'h0010) begin n_err++; $display("FAIL b_setup got %h want 0010", bus.pc); end
    n_cmp++;
    step(I_BEQ, 1, 0, 3'b001, 1, 16'h0);
    if (bus.pc !== 16'h000E || bus.branch_taken !== 1'b1) begin
      n_err++; $display("FAIL b_taken pc=%h taken=%b want 000E/1", bus.pc, bus.branch_taken);
    end
    n_cmp++;
    step(I_ADD, 1, 0, 3'b000, 1, 16'h0);
    if (bus.pc !== 16'h0010 || bus.branch_taken !== 1'b0) begin
      n_err++; $display("FAIL b_pulse pc=%h taken=%b want 0010/0", bus.pc, bus.branch_taken);
    end
    n_cmp++;
    step(I_BEQ, 1, 0, 3'b000, 1, 16'h0);
    if (bus.pc !== 16'h0012 || bus.branch_taken !== 1'b0) begin
      n_err++; $display("FAIL b_not_taken pc=%h taken=%b want 0012/0", bus.pc, bus.branch_taken);
    end
    n_cmp++;
  endtask

  task automatic test_br_wait();
    repeat (7) step(I_ADD, 1, 0, 3'b000, 1, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step(I_BRAL, 1, 0, 3'b000, 0, 16'h1235);
      if (bus.pc !== 16'h0020 || bus.branch_taken !== 1'b0) begin
        n_err++; $display("FAIL br_wait[%0d] pc=%h taken=%b want 0020/0", i, bus.pc, bus.branch_taken);
      end
      n_cmp++;
    end
    // stall must win over valid flags while waiting
    step(I_BRAL, 1, 1, 3'b000, 1, 16'h1235);
    if (bus.pc !== 16'h0020) begin n_err++; $display("FAIL br_stall_wins got %h want 0020", bus.pc); end
    n_cmp++;
    step(I_BRAL, 1, 0, 3'b000, 1, 16'h1235);
    if (bus.pc !== 16'h1234 || bus.branch_taken !== 1'b1) begin
      n_err++; $display("FAIL br_resolve pc=%h taken=%b want 1234/1", bus.pc, bus.branch_taken);
    end
    n_cmp++;
`ifdef PC_PERF_EN
    if (perf !== 16'd2) begin n_err++; $display("FAIL perf_two got %0d want 2", perf); end
    n_cmp++;
`endif
  endtask

  task automatic test_wrap_stall();
    step(I_BRAL, 1, 0, 3'b000, 1, 16'hFFFF);
    if (bus.pc !== 16'hFFFE) begin n_err++; $display("FAIL wrap_setup got %h want FFFE", bus.pc); end
    n_cmp++;
    if (bus.pc_plus2 !== 16'h0000) begin n_err++; $display("FAIL wrap_plus2 got %h want 0000", bus.pc_plus2); end
    n_cmp++;
    step(I_ADD, 1, 0, 3'b000, 1, 16'h0);
    if (bus.pc !== 16'h0000) begin n_err++; $display("FAIL wrap_pc got %h want 0000", bus.pc); end
    n_cmp++;
    step(I_BEQ, 1, 1, 3'b001, 1, 16'h0);
    if (bus.pc !== 16'h0000 || bus.branch_taken !== 1'b0) begin
      n_err++; $display("FAIL stall_hold pc=%h taken=%b want 0000/0", bus.pc, bus.branch_taken);
    end
    n_cmp++;
  endtask

  task automatic test_halt();
    step(I_ADD, 1, 0, 3'b000, 1, 16'h0);
    step(I_HLT, 1, 0, 3'b000, 1, 16'h0);
    if (bus.halted !== 1'b1 || bus.pc !== 16'h0002) begin
      n_err++; $display("FAIL halt_enter halted=%b pc=%h want 1/0002", bus.halted, bus.pc);
    end
    n_cmp++;
    for (int i = 0; i < 10; i++) begin
      step(I_BRAL, 1, 0, 3'b111, 1, 16'h4444);
      if (bus.pc !== 16'h0002 || bus.halted !== 1'b1 || bus.branch_taken !== 1'b0) begin
        n_err++; $display("FAIL halt_frozen[%0d] pc=%h halted=%b taken=%b", i, bus.pc, bus.halted, bus.branch_taken);
      end
      n_cmp++;
    end
    async_reset();
  endtask

  // asserts reset between edges; outputs must clear without a clock edge
  task automatic async_reset();
    #2 rst = 0;
    #1;
    model_reset();
    if (bus.pc !== RST_PC || bus.halted !== 1'b0 || bus.branch_taken !== 1'b0) begin
      n_err++; $display("FAIL async_reset pc=%h halted=%b taken=%b", bus.pc, bus.halted, bus.branch_taken);
    end
    n_cmp++;
    bus.instr_valid = 0;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [15:0] ins, tmp, rs;
    logic [3:0]  op;
    logic [2:0]  fl;
    bit          iv, st, fv;
    int          r;
    ins = I_ADD;
    for (int i = 0; i < 600; i++) begin
      if (!m_wait) begin
        r = $urandom_range(0, 99);
        if (r < 35)      op = 4'hC;
        else if (r < 55) op = 4'hD;
        else if (r < 57) op = 4'hF;
        else begin
          op = 4'($urandom_range(0, 12));
          if (op == 4'hC) op = 4'hE;
        end
        tmp = 16'($urandom);
        ins = {op, tmp[11:0]};
      end
      iv = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 3) == 0);
      fl = 3'($urandom);
      fv = ($urandom_range(0, 2) != 0);
      rs = 16'($urandom);
      step(ins, iv, st, fl, fv, rs);
      if (bus.pc !== 16'(m_pc)) begin n_err++; $display("FAIL rnd_pc[%0d] got %h want %h", i, bus.pc, 16'(m_pc)); end
      n_cmp++;
      if (bus.pc_plus2 !== 16'((m_pc + 2) & 'hFFFF)) begin
        n_err++; $display("FAIL rnd_plus2[%0d] got %h want %h", i, bus.pc_plus2, 16'((m_pc + 2) & 'hFFFF));
      end
      n_cmp++;
      if (bus.branch_taken !== m_taken) begin n_err++; $display("FAIL rnd_taken[%0d] got %b want %b", i, bus.branch_taken, m_taken); end
      n_cmp++;
      if (bus.halted !== m_halt) begin n_err++; $display("FAIL rnd_halted[%0d] got %b want %b", i, bus.halted, m_halt); end
      n_cmp++;
`ifdef PC_PERF_EN
      if (perf !== 16'(m_cnt)) begin n_err++; $display("FAIL rnd_perf[%0d] got %0d want %0d", i, perf, m_cnt); end
      n_cmp++;
`endif
      if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 99) == 0) async_reset();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_b();
    test_br_wait();
    test_wrap_stall();
    test_halt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
